// File: rtl/exec_pipe3.sv
// exec_pipe3: three-stage execute / memory / writeback pipeline.
//
// Decoded bundles arrive through a valid/ready handshake. The EX stage reads
// its operands from the register file, with forwarding from EX/MEM and
// MEM/WB, and latches the ALU result into EX/MEM. The MEM stage accesses
// the data memory. The WB stage retires the result into the register file.
//
// Ports
//   Clk, Reset        clock; synchronous active-high reset
//   in_valid/in_ready bundle handshake (in_ready low only on a load-use hazard)
//   rs1, rs2, rd, imm source/destination indices, sign-extended immediate
//   Operation         ALU op code
//   ALUSrc, RegWrite, MemRead, MemWrite, MemToReg
//                     control bits (MemToReg=1 selects the ALU result)
//   alu_out, zero     EX/MEM registered ALU result and its zero flag
//   wb_valid, wb_rd, wb_data
//                     MEM/WB retiring instruction
//   dbg_raddr/dbg_rdata
//                     combinational register file read port
module exec_pipe3 #(
  parameter  int XLEN       = 64,
  parameter  int NREG       = 32,
  parameter  int DMEM_DEPTH = 64,
  localparam int RW         = $clog2(NREG),
  localparam int DW         = $clog2(DMEM_DEPTH)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RW-1:0]   rs1,
  input  logic [RW-1:0]   rs2,
  input  logic [RW-1:0]   rd,
  input  logic [XLEN-1:0] imm,
  input  logic [3:0]      Operation,
  input  logic            ALUSrc,
  input  logic            RegWrite,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            MemToReg,
  output logic [XLEN-1:0] alu_out,
  output logic            zero,
  output logic            wb_valid,
  output logic [RW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic [RW-1:0]   dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);

  localparam int BO = $clog2(XLEN / 8);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  logic [XLEN-1:0] rf_q   [NREG];
  logic [XLEN-1:0] dmem_q [DMEM_DEPTH];

  // EX/MEM
  logic            ex_valid_q,    ex_valid_d;
  logic [RW-1:0]   ex_rd_q,       ex_rd_d;
  logic            ex_regwrite_q, ex_regwrite_d;
  logic            ex_memread_q,  ex_memread_d;
  logic            ex_memwrite_q, ex_memwrite_d;
  logic            ex_memtoreg_q, ex_memtoreg_d;
  logic [XLEN-1:0] ex_sdata_q,    ex_sdata_d;
  logic [XLEN-1:0] alu_out_q,     alu_out_d;
  logic            zero_q,        zero_d;

  // MEM/WB
  logic            wb_valid_q,    wb_valid_d;
  logic [RW-1:0]   wb_rd_q,       wb_rd_d;
  logic            wb_regwrite_q, wb_regwrite_d;
  logic [XLEN-1:0] wb_data_q,     wb_data_d;

  logic [XLEN-1:0] rs1_val, rs2_val, op_b, alu_res, mem_rdata;
  logic [DW-1:0]   mem_idx;
  logic            stall, accept, mem_we, rf_we;

  // Operand fetch. A load sitting in EX/MEM has no data yet, so it is
  // skipped here; the stall below keeps its consumers out of EX meanwhile.
  always_comb begin
    rs1_val = '0;
    if (rs1 != '0) begin
      if (ex_valid_q && ex_regwrite_q && !ex_memread_q && ex_rd_q == rs1)
        rs1_val = alu_out_q;
      else if (wb_valid_q && wb_regwrite_q && wb_rd_q == rs1)
        rs1_val = wb_data_q;
      else
        rs1_val = rf_q[rs1];
    end
    rs2_val = '0;
    if (rs2 != '0) begin
      if (ex_valid_q && ex_regwrite_q && !ex_memread_q && ex_rd_q == rs2)
        rs2_val = alu_out_q;
      else if (wb_valid_q && wb_regwrite_q && wb_rd_q == rs2)
        rs2_val = wb_data_q;
      else
        rs2_val = rf_q[rs2];
    end
  end

  always_comb begin
    op_b = ALUSrc ? imm : rs2_val;
    case (Operation)
      ALU_AND: alu_res = rs1_val & op_b;
      ALU_OR:  alu_res = rs1_val | op_b;
      ALU_ADD: alu_res = rs1_val + op_b;
      ALU_SUB: alu_res = rs1_val - op_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(op_b)};
      ALU_NOR: alu_res = ~(rs1_val | op_b);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    stall = ex_valid_q && ex_memread_q && (ex_rd_q != '0) &&
            (ex_rd_q == rs1 || ex_rd_q == rs2);
    in_ready = !stall;
    accept   = in_valid && in_ready;
  end

  // EX/MEM: payload is latched only on accept; a refused cycle leaves a bubble.
  always_comb begin
    ex_valid_d    = accept;
    ex_rd_d       = ex_rd_q;
    ex_regwrite_d = ex_regwrite_q;
    ex_memread_d  = ex_memread_q;
    ex_memwrite_d = ex_memwrite_q;
    ex_memtoreg_d = ex_memtoreg_q;
    ex_sdata_d    = ex_sdata_q;
    alu_out_d     = alu_out_q;
    zero_d        = zero_q;
    if (accept) begin
      ex_rd_d       = rd;
      ex_regwrite_d = RegWrite;
      ex_memread_d  = MemRead;
      ex_memwrite_d = MemWrite;
      ex_memtoreg_d = MemToReg;
      ex_sdata_d    = rs2_val;
      alu_out_d     = alu_res;
      zero_d        = (alu_res == '0);
    end
  end

  // MEM: the read is taken before the same-edge store, so a combined
  // read/write returns the old contents.
  always_comb begin
    mem_idx       = alu_out_q[DW+BO-1:BO];
    mem_rdata     = dmem_q[mem_idx];
    mem_we        = ex_valid_q && ex_memwrite_q;
    wb_valid_d    = ex_valid_q;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = wb_regwrite_q;
    wb_data_d     = wb_data_q;
    if (ex_valid_q) begin
      wb_rd_d       = ex_rd_q;
      wb_regwrite_d = ex_regwrite_q;
      wb_data_d     = ex_memtoreg_q ? alu_out_q : mem_rdata;
    end
    rf_we = wb_valid_q && wb_regwrite_q && (wb_rd_q != '0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_valid_q    <= 1'b0;
      ex_rd_q       <= '0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
      ex_memtoreg_q <= 1'b0;
      ex_sdata_q    <= '0;
      alu_out_q     <= '0;
      zero_q        <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_data_q     <= '0;
      for (int unsigned i = 0; i < NREG; i++) rf_q[RW'(i)] <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rd_q       <= ex_rd_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_memread_q  <= ex_memread_d;
      ex_memwrite_q <= ex_memwrite_d;
      ex_memtoreg_q <= ex_memtoreg_d;
      ex_sdata_q    <= ex_sdata_d;
      alu_out_q     <= alu_out_d;
      zero_q        <= zero_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_data_q     <= wb_data_d;
      if (rf_we) rf_q[wb_rd_q] <= wb_data_q;
    end
  end

  // Data memory is not cleared by reset; a store in flight at reset is dropped.
  always_ff @(posedge Clk) begin
    if (!Reset && mem_we) dmem_q[mem_idx] <= ex_sdata_q;
  end

  assign alu_out   = alu_out_q;
  assign zero      = zero_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign dbg_rdata = (dbg_raddr == '0) ? '0 : rf_q[dbg_raddr];

endmodule

// File: tb/tb_exec_pipe3.sv
// tb_exec_pipe3: directed and randomized checks of exec_pipe3 against an
// instruction-level model (architectural registers and memory updated in
// program order, one instruction at a time).
module tb_exec_pipe3;
  localparam int XLEN = 64, NREG = 32, DMEM_DEPTH = 64, RW = 5;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            in_valid, in_ready;
  logic [RW-1:0]   rs1, rs2, rd, wb_rd, dbg_raddr;
  logic [XLEN-1:0] imm, alu_out, wb_data, dbg_rdata;
  logic [3:0]      Operation;
  logic            ALUSrc, RegWrite, MemRead, MemWrite, MemToReg;
  logic            zero, wb_valid;

  always #5 Clk = ~Clk;

  exec_pipe3 #(.XLEN(XLEN), .NREG(NREG), .DMEM_DEPTH(DMEM_DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .Operation(Operation),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .alu_out(alu_out),
    .zero(zero), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [63:0] m_reg [NREG];
  logic [63:0] m_mem [DMEM_DEPTH];
  typedef struct { int rd; logic [63:0] data; } wb_t;
  wb_t wb_q[$];
  int  prev_load_rd = -1;

  function automatic logic [63:0] m_rd(input int r);
    return (r == 0) ? 64'd0 : m_reg[r];
  endfunction

  function automatic logic [63:0] m_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd12: return ~(a | b);
      default: return 64'd0;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] op, input int d, input int s1, input int s2,
                      input logic [63:0] im, input bit asrc, input bit rw,
                      input bit mr, input bit mw, input bit m2r);
    logic [63:0] a, b, res, old, wbv;
    int idx, stalls, exp_stall;
    exp_stall = (prev_load_rd > 0 && (prev_load_rd == s1 || prev_load_rd == s2)) ? 1 : 0;
    Operation = op; rd = RW'(d); rs1 = RW'(s1); rs2 = RW'(s2); imm = im;
    ALUSrc = asrc; RegWrite = rw; MemRead = mr; MemWrite = mw; MemToReg = m2r;
    in_valid = 1'b1;
    #1;
    stalls = 0;
    while (!in_ready && stalls < 8) begin
      @(posedge Clk); #2;
      stalls++;
    end
    chk("stall_cycles", stalls, exp_stall);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    a   = m_rd(s1);
    b   = asrc ? im : m_rd(s2);
    res = m_alu(op, a, b);
    idx = int'((res >> 3) % DMEM_DEPTH);
    old = m_mem[idx];
    if (mw) m_mem[idx] = m_rd(s2);
    wbv = m2r ? res : old;
    if (rw && d != 0) m_reg[d] = wbv;
    prev_load_rd = mr ? d : -1;
    @(posedge Clk);
    wb_q.push_back('{d, wbv});
    #1;
    in_valid = 1'b0;
    chk("alu_out", alu_out, res);
    chk("zero", zero, res == 64'd0);
  endtask

  task automatic alu_r(input logic [3:0] op, input int d, input int s1, input int s2);
    send(op, d, s1, s2, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic alu_i(input logic [3:0] op, input int d, input int s1, input logic [63:0] im);
    send(op, d, s1, 0, im, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic lw(input int d, input int s1, input logic [63:0] im);
    send(4'd2, d, s1, 0, im, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic sw(input int s2, input int s1, input logic [63:0] im);
    send(4'd2, 0, s1, s2, im, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
    prev_load_rd = -1;
  endtask

  task automatic check_regs(input string tag);
    for (int r = 0; r < NREG; r++) begin
      dbg_raddr = RW'(r);
      #1;
      chk(tag, dbg_rdata, m_rd(r));
    end
    @(posedge Clk); #1;
  endtask

  task automatic dbg_expect(input string tag, input int r, input logic [63:0] v);
    dbg_raddr = RW'(r);
    #1;
    chk(tag, dbg_rdata, v);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    in_valid = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    wb_q.delete();
    for (int r = 0; r < NREG; r++) m_reg[r] = 64'd0;
    prev_load_rd = -1;
  endtask

  // Retirement monitor: every wb_valid cycle must match the oldest accepted bundle.
  initial begin
    wb_t e;
    forever begin
      @(negedge Clk);
      if (wb_valid) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 64'd1, 64'd0);
        else begin
          e = wb_q.pop_front();
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] saved;
    logic [3:0]  ops [8];
    int kind, d, s1, s2;
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd6;
    ops[4] = 4'd7; ops[5] = 4'd12; ops[6] = 4'd15; ops[7] = 4'd3;
    Reset = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    Operation = '0; ALUSrc = 0; RegWrite = 0; MemRead = 0; MemWrite = 0;
    MemToReg = 0; dbg_raddr = '0;
    for (int w = 0; w < DMEM_DEPTH; w++) m_mem[w] = 64'd0;
    @(posedge Clk); #1;
    do_reset();

    // Reset state
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_alu_out", alu_out, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    check_regs("rst_rf");

    // Give every memory word a known value
    for (int w = 0; w < DMEM_DEPTH; w++) sw(0, 0, 64'(w * 8));

    // Back-to-back dependent ALU chain
    alu_i(4'd2, 15, 0, 64'd14);
    alu_i(4'd2, 6, 0, 64'd2);
    alu_i(4'd2, 7, 0, 64'd3);
    alu_r(4'd2, 5, 6, 7);
    alu_r(4'd2, 5, 15, 5);
    alu_r(4'd6, 15, 15, 6);
    idle(3);
    dbg_expect("x5_seq", 5, 64'd19);
    dbg_expect("x15_seq", 15, 64'd12);
    check_regs("rf_seq");

    // Store, load, load-use
    sw(5, 15, 64'd0);
    lw(8, 0, 64'd12);
    alu_r(4'd2, 9, 8, 8);
    idle(3);
    dbg_expect("x9_loaduse", 9, 64'd38);

    // Compare / SLT / unknown op
    alu_r(4'd6, 10, 5, 5);
    alu_i(4'd2, 11, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    alu_i(4'd2, 12, 0, 64'd1);
    alu_r(4'd7, 13, 11, 12);
    alu_r(4'd15, 14, 5, 5);
    idle(3);
    dbg_expect("x13_slt", 13, 64'd1);

    // x0 protection
    alu_i(4'd2, 0, 0, 64'd7);
    alu_r(4'd2, 1, 0, 0);
    idle(3);
    dbg_expect("x1_zero", 1, 64'd0);
    dbg_expect("x0_zero", 0, 64'd0);

    // Reset while a store sits in EX/MEM
    alu_i(4'd2, 2, 0, 64'h55);
    sw(2, 0, 64'd24);
    idle(3);
    alu_i(4'd2, 3, 0, 64'h77);
    saved = m_mem[3];
    sw(3, 0, 64'd24);
    do_reset();
    m_mem[3] = saved;  // the squashed store never reaches memory
    chk("rst2_wb_valid", wb_valid, 1'b0);
    check_regs("rst2_rf");
    lw(4, 0, 64'd24);
    idle(3);
    dbg_expect("word3_kept", 4, 64'h55);

    // Randomized traffic
    repeat (400) begin
      kind = $urandom_range(0, 9);
      d  = $urandom_range(0, 7);
      s1 = $urandom_range(0, 7);
      s2 = $urandom_range(0, 7);
      case (kind)
        0, 1, 2, 3: alu_r(ops[$urandom_range(0, 7)], d, s1, s2);
        4, 5:       alu_i(ops[$urandom_range(0, 7)], d, s1, {$urandom, $urandom});
        6, 7:       lw(d, s1, 64'($urandom_range(0, 4095)));
        8:          sw(s2, s1, 64'($urandom_range(0, 4095)));
        default: begin
          if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
          else send(4'd2, d, s1, s2, 64'($urandom_range(0, 4095)), 1'b1,
                    1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'($urandom_range(0, 1)));
        end
      endcase
    end
    idle(3);
    check_regs("rf_final");
    chk("wb_pending", 64'(wb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
